// File: rtl/pre_adder_arbiter.sv
// pre_adder_arbiter
//   Shares one external pre-adder multiply datapath, res = (a + c) * b, among N_REQ
//   requesters. Operand requests are arbitrated round-robin over valid/ready. A tag
//   pipeline follows each operation through the datapath latency. Results return with
//   their requester id through a first-word fall-through FIFO with back-pressure.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   req_valid_i/_o     per-requester operand valid / accept (at most one ready bit high)
//   req_a/b/c_i        packed per-requester operands (24/18/24 bits each)
//   dp_a/b/c_o         operands to the datapath, zero on non-issue cycles
//   dp_res_i           datapath result, LATENCY cycles after issue
//   rsp_valid_o/_i     response handshake (valid = FIFO not empty)
//   rsp_id_o, rsp_res_o head response requester index and result
//   busy_o             any op in flight or FIFO not empty
module pre_adder_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_REQ-1:0]    req_valid_i,
   output logic [N_REQ-1:0]    req_ready_o,
   input  logic [N_REQ*24-1:0] req_a_i,
   input  logic [N_REQ*18-1:0] req_b_i,
   input  logic [N_REQ*24-1:0] req_c_i,
   output logic [23:0]         dp_a_o,
   output logic [17:0]         dp_b_o,
   output logic [23:0]         dp_c_o,
   input  logic [42:0]         dp_res_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [IDW-1:0]      rsp_id_o,
   output logic [42:0]         rsp_res_o,
   output logic                busy_o
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [IDW-1:0]     tag_id_q [LATENCY];
   logic [IDW-1:0]     tag_id_d [LATENCY];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [IDW-1:0]     fifo_id_q [FIFO_DEPTH];
   logic [42:0]        fifo_res_q [FIFO_DEPTH];

   logic               grant_found;
   logic [IDW-1:0]     grant_idx, cand;
   logic               credit_ok, issue, push, pop, fifo_empty;
   int unsigned        occupancy;

   // Round-robin search starting at ptr_q, wrapping modulo N_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IDW'((32'(ptr_q) + i) % N_REQ);
         if (!grant_found && req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Every op in flight already owns a FIFO slot, so a push can never overflow.
   // A pop in this cycle deliberately does not return credit until the next one.
   always_comb begin
      occupancy = 32'(count_q);
      for (int unsigned i = 0; i < LATENCY; i++) begin
         occupancy = occupancy + 32'(tag_vld_q[i]);
      end
   end

   assign credit_ok = occupancy < FIFO_DEPTH;
   // Gating with rst_ni keeps ready and the datapath operands low while in reset.
   assign issue     = rst_ni & grant_found & credit_ok;

   always_comb begin
      req_ready_o = '0;
      dp_a_o      = '0;
      dp_b_o      = '0;
      dp_c_o      = '0;
      if (issue) begin
         req_ready_o[grant_idx] = 1'b1;
         dp_a_o = req_a_i[24*grant_idx +: 24];
         dp_b_o = req_b_i[18*grant_idx +: 18];
         dp_c_o = req_c_i[24*grant_idx +: 24];
      end
   end

   assign fifo_empty  = (count_q == '0);
   assign rsp_valid_o = !fifo_empty;
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign push        = tag_vld_q[LATENCY-1];
   assign rsp_id_o    = fifo_empty ? '0 : fifo_id_q[rd_ptr_q];
   assign rsp_res_o   = fifo_empty ? '0 : fifo_res_q[rd_ptr_q];
   assign busy_o      = (occupancy != 0);

   always_comb begin
      ptr_d = ptr_q;
      if (issue) begin
         ptr_d = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDW'(1);
      end

      tag_vld_d    = '0;
      tag_vld_d[0] = issue;
      tag_id_d[0]  = grant_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (32'(wr_ptr_q) == FIFO_DEPTH - 1) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (32'(rd_ptr_q) == FIFO_DEPTH - 1) ? '0 : rd_ptr_q + PW'(1);
      end

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q     <= '0;
         tag_vld_q <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_id_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         tag_vld_q <= tag_vld_d;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_id_q[i] <= tag_id_d[i];
         end
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // Storage needs no reset: the outputs are masked while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_id_q[wr_ptr_q]  <= tag_id_q[LATENCY-1];
         fifo_res_q[wr_ptr_q] <= dp_res_i;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
                    push |-> (pop || (count_q < CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_pre_adder_arbiter.sv
module tb_pre_adder_arbiter;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dp_rst;
   logic [3:0]  req_valid, req_ready;
   logic [95:0] req_a, req_c;
   logic [71:0] req_b;
   logic [23:0] dp_a, dp_c;
   logic [17:0] dp_b;
   logic [42:0] dp_res, rsp_res;
   logic        rsp_valid, rsp_ready, busy;
   logic [1:0]  rsp_id;
   logic [23:0] ta [4];
   logic [23:0] tc [4];
   logic [17:0] tb [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign req_a[24*k +: 24] = ta[k];
      assign req_b[18*k +: 18] = tb[k];
      assign req_c[24*k +: 24] = tc[k];
   end

   pre_adder_arbiter #(.N_REQ(4), .LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
      .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_c_o(dp_c), .dp_res_i(dp_res),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_res_o(rsp_res), .busy_o(busy)
   );

   // Two-stage pre-adder multiply datapath with active-high reset.
   logic signed [42:0] dp_s1, dp_s2;
   assign dp_rst = ~rst_n;
   always_ff @(posedge clk or posedge dp_rst) begin
      if (dp_rst) begin
         dp_s1 <= '0;
         dp_s2 <= '0;
      end else begin
         dp_s1 <= ($signed({{19{dp_a[23]}}, dp_a}) + $signed({{19{dp_c[23]}}, dp_c}))
                  * $signed({{25{dp_b[17]}}, dp_b});
         dp_s2 <= dp_s1;
      end
   end
   assign dp_res = dp_s2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Reference model: pointer after last grant, outstanding-op count, expected response queue.
   typedef struct {
      logic [1:0]  id;
      logic [42:0] res;
      int          due;
   } exp_t;
   exp_t q[$];
   int   mptr, occ, cyc_now;

   task automatic model_step();
      int         g;
      logic [3:0] er;
      logic       ev;
      exp_t       e;
      longint     v;
      g = -1;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (mptr + i) % N;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      er = 4'b0;
      if (g >= 0 && occ < 4) er[g] = 1'b1;
      chk("rand_ready", 64'(req_ready), 64'(er));
      ev = (q.size() > 0) && (q[0].due <= cyc_now);
      chk("rand_rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev && rsp_ready) begin
         chk("rand_rsp_id", 64'(rsp_id), 64'(q[0].id));
         chk("rand_rsp_res", 64'(rsp_res), 64'(q[0].res));
         void'(q.pop_front());
         occ--;
      end
      if (er != 4'b0) begin
         chk("rand_dp_ops", 64'({dp_a, dp_b, dp_c}), 64'({ta[g], tb[g], tc[g]}));
         v = (longint'($signed(ta[g])) + longint'($signed(tc[g]))) * longint'($signed(tb[g]));
         e.id  = 2'(g);
         e.res = v[42:0];
         e.due = cyc_now + 3;
         q.push_back(e);
         mptr = (g + 1) % N;
         occ++;
      end
      cyc_now++;
   endtask

   typedef struct {
      int          req;
      logic [23:0] a;
      logic [17:0] b;
      logic [23:0] c;
      longint      res;
   } vec_t;
   vec_t tbl [5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [42:0] e43;
      logic [3:0]  oh;
      int          cnt, rc, resumed;

      tbl[0] = '{0, 24'd5,       18'h3FFFE, 24'd3,       -64'sd16};
      tbl[1] = '{2, 24'h7FFFFF,  18'h20000, 24'h7FFFFF,  -64'sd2199022993408};
      tbl[2] = '{1, 24'h800000,  18'h20000, 24'h800000,  64'sd2199023255552};
      tbl[3] = '{3, 24'hFFFF9C,  18'd7,     24'd40,      -64'sd420};
      tbl[4] = '{0, 24'd1000,    18'h1FFFF, 24'hFFFFFF,  64'sd130939929};

      for (int k = 0; k < N; k++) begin
         ta[k] = 24'(k + 1);
         tb[k] = 18'd2;
         tc[k] = 24'd1;
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;

      // Outputs held in reset even with all requests valid.
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_dp_a", 64'(dp_a), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_res", 64'(rsp_res), 64'(0));
      do_reset();

      // Single operations: latency, id, result and idle afterwards.
      for (int i = 0; i < 5; i++) begin
         ta[tbl[i].req] = tbl[i].a;
         tb[tbl[i].req] = tbl[i].b;
         tc[tbl[i].req] = tbl[i].c;
         req_valid = 4'(1 << tbl[i].req);
         rsp_ready = 1'b0;
         @(negedge clk);
         chk("vec_ready", 64'(req_ready), 64'(req_valid));
         chk("vec_dp_ops", 64'({dp_a, dp_b, dp_c}), 64'({tbl[i].a, tbl[i].b, tbl[i].c}));
         step();
         req_valid = '0;
         @(negedge clk);
         chk("vec_valid_t1", 64'(rsp_valid), 64'(0));
         step();
         @(negedge clk);
         chk("vec_valid_t2", 64'(rsp_valid), 64'(0));
         step();
         @(negedge clk);
         e43 = tbl[i].res[42:0];
         chk("vec_valid_t3", 64'(rsp_valid), 64'(1));
         chk("vec_id", 64'(rsp_id), 64'(tbl[i].req));
         chk("vec_res", 64'(rsp_res), 64'(e43));
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         @(negedge clk);
         chk("vec_busy_after", 64'(busy), 64'(0));
         chk("vec_valid_after", 64'(rsp_valid), 64'(0));
         step();
      end

      // All requesters streaming: strict rotation, one per cycle, ids returned in order.
      do_reset();
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      rc = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c < 16) begin
            oh = 4'b1 << (c % 4);
            chk("rr_grant", 64'(req_ready), 64'(oh));
         end
         if (rsp_valid) begin
            chk("rr_rsp_id", 64'(rsp_id), 64'(rc % 4));
            rc++;
         end
         step();
         if (c == 15) req_valid = '0;
      end
      chk("rr_rsp_count", 64'(rc), 64'(16));

      // Back-pressure: credit stops issue at FIFO_DEPTH, then drains in order.
      do_reset();
      ta[1] = 24'd1; tb[1] = 18'd1; tc[1] = 24'd0;
      req_valid = 4'b0010;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (req_ready[1]) cnt++;
         step();
         if (req_ready[1]) ta[1] = ta[1] + 24'd1;
      end
      chk("bp_issue_count", 64'(cnt), 64'(4));
      @(negedge clk);
      chk("bp_ready_low", 64'(req_ready), 64'(0));
      rsp_ready = 1'b1;
      resumed = 0;
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         chk("bp_drain_valid", 64'(rsp_valid), 64'(1));
         chk("bp_drain_id", 64'(rsp_id), 64'(1));
         chk("bp_drain_res", 64'(rsp_res), 64'(j + 1));
         if (req_ready[1]) resumed++;
         step();
      end
      chk("bp_resumed", 64'(resumed), 64'(3));
      req_valid = '0;
      repeat (8) step();
      @(negedge clk);
      chk("bp_idle", 64'(busy), 64'(0));

      // Pointer wrap: grant 3, then 0 wins with ptr=0, then 3.
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b1000;
      @(negedge clk);
      chk("wrap_g3", 64'(req_ready), 64'(4'b1000));
      step();
      req_valid = 4'b1001;
      @(negedge clk);
      chk("wrap_g0", 64'(req_ready), 64'(4'b0001));
      step();
      @(negedge clk);
      chk("wrap_g3b", 64'(req_ready), 64'(4'b1000));
      step();
      req_valid = '0;
      repeat (6) step();

      // Reset with two ops in flight and one in the FIFO.
      do_reset();
      req_valid = 4'b0100;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("mid_issue", 64'(req_ready), 64'(4'b0100));
         step();
      end
      req_valid = '0;
      @(negedge clk);
      chk("mid_valid_pre", 64'(rsp_valid), 64'(1));
      chk("mid_busy_pre", 64'(busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid_rst", 64'(rsp_valid), 64'(0));
      chk("mid_busy_rst", 64'(busy), 64'(0));
      chk("mid_res_rst", 64'(rsp_res), 64'(0));
      repeat (2) step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      cnt = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
         step();
      end
      chk("mid_no_rsp", 64'(cnt), 64'(0));

      // Randomized traffic against the reference model.
      do_reset();
      q.delete();
      mptr = 0; occ = 0; cyc_now = 0;
      for (int c = 0; c < 430; c++) begin
         @(negedge clk);
         model_step();
         step();
         if (c < 400) begin
            req_valid = 4'($urandom);
            for (int k = 0; k < N; k++) begin
               ta[k] = 24'($urandom);
               tb[k] = 18'($urandom);
               tc[k] = 24'($urandom);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
         end else begin
            req_valid = '0;
            rsp_ready = 1'b1;
         end
      end
      chk("rand_queue_empty", 64'(q.size()), 64'(0));
      @(negedge clk);
      chk("rand_idle", 64'(busy), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
